// File: rtl/kp_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | kp_pkg : key codes, keypad map and BCD helper for keypad entry    |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
package kp_pkg;

  localparam int VAL_W       = 10;
  localparam int MAG_POS_MAX = 511;
  localparam int MAG_NEG_MAX = 512;

  typedef enum logic [3:0] {
    KEY_0     = 4'd0,
    KEY_1     = 4'd1,
    KEY_2     = 4'd2,
    KEY_3     = 4'd3,
    KEY_4     = 4'd4,
    KEY_5     = 4'd5,
    KEY_6     = 4'd6,
    KEY_7     = 4'd7,
    KEY_8     = 4'd8,
    KEY_9     = 4'd9,
    KEY_SIGN  = 4'd10,
    KEY_ENTER = 4'd11,
    KEY_CLR   = 4'd12,
    KEY_BKSP  = 4'd13,
    KEY_NONE  = 4'd15
  } key_t;

  // Nibble k holds the key at index k = row*4+col; index 0 sits in the low nibble.
  localparam logic [63:0] KEYMAP = {
    KEY_NONE, KEY_ENTER, KEY_0, KEY_SIGN,
    KEY_NONE, KEY_9,     KEY_8, KEY_7,
    KEY_BKSP, KEY_6,     KEY_5, KEY_4,
    KEY_CLR,  KEY_3,     KEY_2, KEY_1
  };

  function automatic key_t keymap_lookup(input logic [3:0] idx);
    return key_t'(KEYMAP[{idx, 2'b00} +: 4]);
  endfunction

  function automatic logic [VAL_W-1:0] bcd3_to_bin(input logic [3:0] d2,
                                                   input logic [3:0] d1,
                                                   input logic [3:0] d0);
    return ({6'd0, d2} * 10'd100) + ({6'd0, d1} * 10'd10) + {6'd0, d0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/kp_debounce.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | kp_debounce : per-scan press/release debounce, one event per press|
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module kp_debounce
  import kp_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scan_done,
  input  key_t code,
  output logic key_evt,
  output key_t key_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [0:0] {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } db_state_t;

  db_state_t        state;
  key_t             cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Saturating run length of the current candidate code.
  always_comb begin
    cnt_next = CNT_W'(1);
    if (code == cand) begin
      cnt_next = (cnt == CNT_TGT) ? cnt : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RELEASED;
      cand     <= KEY_NONE;
      cnt      <= '0;
      key_evt  <= 1'b0;
      key_code <= KEY_NONE;
    end else begin
      key_evt <= 1'b0;
      if (scan_done) begin
        cand <= code;
        cnt  <= cnt_next;
        case (state)
          ST_RELEASED: begin
            if (code != KEY_NONE && cnt_next >= CNT_TGT) begin
              key_evt  <= 1'b1;
              key_code <= code;
              state    <= ST_PRESSED;
              cand     <= KEY_NONE;
              cnt      <= '0;
            end
          end
          ST_PRESSED: begin
            if (code == KEY_NONE && cnt_next >= CNT_TGT) begin
              state <= ST_RELEASED;
              cand  <= KEY_NONE;
              cnt   <= '0;
            end
          end
          default: state <= ST_RELEASED;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_entry_scanner.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | keypad_entry_scanner : 4x4 keypad scan, debounce, signed entry    |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module keypad_entry_scanner
  import kp_pkg::*;
#(
  parameter int SCAN_DIV       = 250,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_DIGITS     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_drive,
  output logic [VAL_W-1:0] live_mag,
  output logic             live_neg,
  output logic [VAL_W-1:0] value_out,
  output logic             value_valid,
  output logic             entry_err
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DIG_W = 4 * MAX_DIGITS;
  localparam int N_W   = $clog2(MAX_DIGITS + 1);

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col;
  logic [15:0]      snapshot;
  logic             scan_done;
  logic             slot_last;

  logic [4:0]       key_cnt;
  logic [3:0]       hit_idx;
  key_t             scan_code;

  logic             key_evt;
  key_t             key_code;

  logic [DIG_W-1:0] digits;
  logic [DIG_W-1:0] digits_nxt;
  logic [N_W-1:0]   n;
  logic [N_W-1:0]   n_nxt;
  logic             neg_nxt;
  logic             commit;
  logic             reject;
  logic [VAL_W-1:0] cur_mag;
  logic [VAL_W-1:0] signed_val;
  logic             mag_ok;

  assign slot_last = (div_cnt == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      div_cnt   <= '0;
      col       <= 2'd0;
      col_drive <= 4'b1110;
      snapshot  <= '0;
      scan_done <= 1'b0;
    end else begin
      row_meta  <= row_in;
      row_sync  <= row_meta;
      scan_done <= 1'b0;
      if (slot_last) begin
        div_cnt   <= '0;
        col       <= col + 2'd1;
        col_drive <= {col_drive[2:0], col_drive[3]};
        // Stored active-high: bit 4*col+row set means that key is down.
        snapshot[{col, 2'b00} +: 4] <= ~row_sync;
        scan_done <= (col == 2'd3);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Snapshot is column-major, the keymap is row-major: swap the index halves.
  always_comb begin
    key_cnt   = 5'd0;
    hit_idx   = 4'd0;
    scan_code = KEY_NONE;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        key_cnt = key_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
    if (key_cnt == 5'd1) begin
      scan_code = keymap_lookup({hit_idx[1:0], hit_idx[3:2]});
    end
  end

  kp_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_done(scan_done),
    .code     (scan_code),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  assign cur_mag    = bcd3_to_bin(digits[11:8], digits[7:4], digits[3:0]);
  assign signed_val = live_neg ? (~cur_mag + VAL_W'(1)) : cur_mag;
  assign mag_ok     = live_neg ? (cur_mag <= VAL_W'(MAG_NEG_MAX))
                               : (cur_mag <= VAL_W'(MAG_POS_MAX));

  always_comb begin
    digits_nxt = digits;
    n_nxt      = n;
    neg_nxt    = live_neg;
    commit     = 1'b0;
    reject     = 1'b0;
    if (key_evt) begin
      case (key_code)
        KEY_SIGN: neg_nxt = ~live_neg;
        KEY_CLR: begin
          digits_nxt = '0;
          n_nxt      = '0;
          neg_nxt    = 1'b0;
        end
        KEY_BKSP: begin
          if (n != '0) begin
            digits_nxt = {4'h0, digits[DIG_W-1:4]};
            n_nxt      = n - N_W'(1);
          end
        end
        KEY_ENTER: begin
          if (mag_ok) begin
            commit     = 1'b1;
            digits_nxt = '0;
            n_nxt      = '0;
            neg_nxt    = 1'b0;
          end else begin
            reject = 1'b1;
          end
        end
        KEY_NONE: ;
        default: begin
          if (n < N_W'(MAX_DIGITS)) begin
            digits_nxt = {digits[DIG_W-5:0], key_code};
            n_nxt      = n + N_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      n           <= '0;
      live_neg    <= 1'b0;
      live_mag    <= '0;
      value_out   <= '0;
      value_valid <= 1'b0;
      entry_err   <= 1'b0;
    end else begin
      digits      <= digits_nxt;
      n           <= n_nxt;
      live_neg    <= neg_nxt;
      live_mag    <= bcd3_to_bin(digits_nxt[11:8], digits_nxt[7:4], digits_nxt[3:0]);
      value_valid <= commit;
      entry_err   <= reject;
      if (commit) begin
        value_out <= signed_val;
      end
    end
  end

endmodule
`default_nettype wire
